seq_mult_n: RTL and testbench
=============================

# seq_mult_n

Parametrised sequential signed multiplier: WIDTH-bit two's-complement add-shift datapath producing a 2·WIDTH-bit product in the A:B register pair plus sign bit X. It is the generalised successor of the lab 8-bit multiplier core and sits between the switch/button front end and the hex-display driver in the top level. Adds a run-release handshake, an explicit Busy/Done status and an optional accumulate mode.

## Interface
- WIDTH, 8: operand width; A, B and S registers are WIDTH bits; range 2–32.
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Load_Clr  in  1  synchronous: load B from Sw, clear A and X (IDLE only).
- Run  in  1  level; starts a multiply when high in IDLE.
- Sw  in  WIDTH  operand input; B source on Load_Clr, multiplicand S on start.
- Accum  in  1  start in accumulate mode; port exists only with SEQ_MULT_ACCUM_EN.
- Aval  out  WIDTH  A register, product high half.
- Bval  out  WIDTH  B register, product low half.
- X  out  1  sign-extension bit of product.
- Busy  out  1  high in COMPUTE.
- Done  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, COMPUTE, DONE, WAIT_REL. Reset: IDLE, A=B=S=0, X=0, count=0, Busy=0, Done=0.
- IDLE: Load_Clr=1 → B←Sw, A←0, X←0, stay IDLE. Else Run=1 → S←Sw, count←0, A←0 and X←0 (unless accumulate start), → COMPUTE. Load_Clr and Run together: Load_Clr wins, Run ignored that cycle.
- COMPUTE, one iteration per cycle: if B[0]=1, X:A ← X:A + sext(S) for count<WIDTH-1, X:A ← X:A − sext(S) for count=WIDTH-1; then arithmetic right shift of X:A:B by one (X preserved, A[0]→B[MSB]). Add/subtract at WIDTH+1 bits, carry-out discarded. count increments; after iteration WIDTH-1 → DONE.
- DONE: Done=1 for one cycle → WAIT_REL.
- WAIT_REL: stay until Run=0, then → IDLE. A held Run never starts a second multiply.
- Result: X:A:B = signed(S) × signed(B_initial), sign-extended to 2·WIDTH+1 bits.
- Load_Clr, Run, Sw changes ignored outside IDLE (Sw except when sampled). S latched at start.
- Repeated Run without Load_Clr: multiplies current B (old product low half) by new Sw.
- Reset_n asserted mid-COMPUTE: immediate abort, all registers to reset values.

## Timing
- Run sampled high at edge k (IDLE) → COMPUTE from k; iterations at edges k+1..k+WIDTH; Done high during cycle after edge k+WIDTH+... i.e. state DONE entered at edge k+WIDTH, Done=1 for that cycle only.
- Busy high from edge k to edge k+WIDTH. Latency Run→Done = WIDTH+1 cycles.
- Aval/Bval/X are registered; valid and stable from DONE until the next Load_Clr or start.

## Configuration
- SEQ_MULT_ACCUM_EN defined: Accum port present; start with Accum=1 keeps A and sets X←A[MSB]; result = sext(A_initial) + S×B_initial.
- Undefined: no Accum port; every start clears A and X.

## Structure
- seq_mult_pkg: state enum type, counter width function (clog2 of WIDTH).
- One sub-module natural: addsub_n (WIDTH+1-bit adder/subtractor, combinational, sub input selects two's-complement of S).

## Test plan
- WIDTH=8: Load_Clr with Sw=0x07, Run with Sw=0xC5 → after 9 cycles Done pulse, Aval=0xFE, Bval=0x63, X=1.
- 0x80×0x80 → Aval=0x40, Bval=0x00, X=0; 0x7F×0x81 → Aval=0xC0, Bval=0xFF, X=1.
- Run held 30 cycles after first result → exactly one Done; release, Run with Sw=0x02 → Aval=0x00, Bval=0xC6, X=0 (0x63×2).
- Reset_n low during cycle 4 of COMPUTE → all outputs 0 immediately, IDLE; subsequent Load_Clr/Run works normally.
- Load_Clr and Run together in IDLE → B loaded, no start, Busy=0; Load_Clr during COMPUTE → ignored, product unchanged.
- SEQ_MULT_ACCUM_EN: from Aval=0xFE, Bval=0x63, Run with Accum=1, Sw=0x02 → Aval=0x00, Bval=0xC4, X=0.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// +--------------------------------------------------------------------+
// | seq_mult_pkg : shared state type and counter sizing for seq_mult_n |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMPUTE  = 2'd1,
      ST_DONE     = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_t;

   // Iteration counter only needs to reach WIDTH-1; keep at least one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_n.sv
// +--------------------------------------------------------------------+
// | addsub_n : N-bit combinational adder/subtractor, carry discarded   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module addsub_n #(
   parameter int N = 9
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_sub,
   output logic [N-1:0] o_y
);

   // Subtract as a + ~b + 1 so one adder serves both operations.
   assign o_y = i_a + (i_b ^ {N{i_sub}}) + {{(N-1){1'b0}}, i_sub};

endmodule

`default_nettype wire

// File: rtl/seq_mult_n.sv
// +--------------------------------------------------------------------+
// | seq_mult_n : WIDTH-bit signed add-shift multiplier, X:A:B product  |
// | Optional accumulate start enabled by macro SEQ_MULT_ACCUM_EN       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_mult_n
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Load_Clr,
   input  logic             Run,
   input  logic [WIDTH-1:0] Sw,
`ifdef SEQ_MULT_ACCUM_EN
   input  logic             Accum,
`endif
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   localparam int                 c_cnt_w = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_s;
   logic               r_x;
   logic [c_cnt_w-1:0] r_count;
   logic               w_load;
   logic               w_start;
   logic               w_iter;
   logic               w_accum;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_xa;

`ifdef SEQ_MULT_ACCUM_EN
   assign w_accum = Accum;
`else
   assign w_accum = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_start     = 1'b0;
      w_iter      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Load_Clr) begin
               w_load = 1'b1;
            end else if (Run) begin
               w_start     = 1'b1;
               w_state_nxt = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            w_iter = 1'b1;
            if (r_count == c_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            if (!Run) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Last iteration weighs the multiplier sign bit at -2^(WIDTH-1).
   addsub_n #(
      .N (WIDTH + 1)
   ) u_addsub (
      .i_a   ({r_x, r_a}),
      .i_b   ({r_s[WIDTH-1], r_s}),
      .i_sub (r_count == c_last),
      .o_y   (w_sum)
   );

   assign w_xa = r_b[0] ? w_sum : {r_x, r_a};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_x     <= 1'b0;
         r_count <= '0;
      end else if (w_load) begin
         r_b <= Sw;
         r_a <= '0;
         r_x <= 1'b0;
      end else if (w_start) begin
         r_s     <= Sw;
         r_count <= '0;
         if (w_accum) begin
            r_x <= r_a[WIDTH-1];
         end else begin
            r_a <= '0;
            r_x <= 1'b0;
         end
      end else if (w_iter) begin
         r_x     <= w_xa[WIDTH];
         r_a     <= w_xa[WIDTH:1];
         r_b     <= {w_xa[0], r_b[WIDTH-1:1]};
         r_count <= r_count + c_cnt_w'(1);
      end
   end

   assign Aval = r_a;
   assign Bval = r_b;
   assign X    = r_x;
   assign Busy = (r_state == ST_COMPUTE);
   assign Done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_n.sv
// +--------------------------------------------------------------------+
// | tb_seq_mult_n : directed self-checking bench for seq_mult_n        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_mult_n;

   localparam int WIDTH = 8;

   logic             Clk;
   logic             Reset_n;
   logic             Load_Clr;
   logic             Run;
   logic [WIDTH-1:0] Sw;
   logic             Accum;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             X;
   logic             Busy;
   logic             Done;

   int n_checks;
   int n_errors;

   seq_mult_n #(
      .WIDTH (WIDTH)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Load_Clr (Load_Clr),
      .Run      (Run),
      .Sw       (Sw),
`ifdef SEQ_MULT_ACCUM_EN
      .Accum    (Accum),
`endif
      .Aval     (Aval),
      .Bval     (Bval),
      .X        (X),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] val);
      Load_Clr = 1'b1;
      Sw       = val;
      tick();
      Load_Clr = 1'b0;
   endtask

   // Start a multiply, disturb Sw (and optionally Load_Clr) while busy,
   // then check latency, single Done pulse and the product.
   task automatic do_mult(input string tag, input logic [WIDTH-1:0] sw, input logic acc,
                          input logic disturb, input logic hold,
                          input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb, input logic ex);
      int n;
      int pulses;
      Sw    = sw;
      Run   = 1'b1;
      Accum = acc;
      tick();
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      Sw    = ~sw;
      Accum = 1'b0;
      if (disturb) Load_Clr = 1'b1;
      n = 0;
      while (!Done && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(WIDTH));
      check({tag, "_aval"}, 32'(Aval), 32'(ea));
      check({tag, "_bval"}, 32'(Bval), 32'(eb));
      check({tag, "_x"}, 32'(X), 32'(ex));
      tick();
      check({tag, "_done_pulse"}, 32'(Done), 32'd0);
      if (hold) begin
         pulses = 0;
         for (int i = 0; i < 30; i++) begin
            tick();
            if (Done || Busy) pulses++;
         end
         check({tag, "_held_run"}, 32'(pulses), 32'd0);
         check({tag, "_held_aval"}, 32'(Aval), 32'(ea));
      end
      Load_Clr = 1'b0;
      Run      = 1'b0;
      tick();
      tick();
      check({tag, "_idle"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Reset_n  = 1'b0;
      Load_Clr = 1'b0;
      Run      = 1'b0;
      Sw       = '0;
      Accum    = 1'b0;
      #7;
      check("rst_aval", 32'(Aval), 32'd0);
      check("rst_bval", 32'(Bval), 32'd0);
      check("rst_x", 32'(X), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      #1 Reset_n = 1'b1;
      tick();

      // 7 * -59 = -413, held Run must not restart
      do_load(8'h07);
      do_mult("m07xc5", 8'hC5, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h63, 1'b1);
      // 0x63 * 2 = 198 reusing old low half as B
      do_mult("rerun", 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC6, 1'b0);

      // -128 * -128 = 16384
      do_load(8'h80);
      do_mult("m80x80", 8'h80, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0);

      // 127 * -127 = -16129
      do_load(8'h81);
      do_mult("m7fx81", 8'h7F, 1'b0, 1'b0, 1'b0, 8'hC0, 8'hFF, 1'b1);

      // Load_Clr and Run together: load wins
      Load_Clr = 1'b1;
      Run      = 1'b1;
      Sw       = 8'h05;
      tick();
      check("both_busy", 32'(Busy), 32'd0);
      check("both_bval", 32'(Bval), 32'h05);
      check("both_aval", 32'(Aval), 32'd0);
      Load_Clr = 1'b0;
      Run      = 1'b0;
      tick();
      check("both_idle", 32'(Busy), 32'd0);

      // Load_Clr during COMPUTE ignored: 4 * 3 = 12
      do_load(8'h03);
      do_mult("ldclr_busy", 8'h04, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 1'b0);

      // Asynchronous reset in cycle 4 of COMPUTE
      do_load(8'h07);
      Sw  = 8'hC5;
      Run = 1'b1;
      tick();
      Run = 1'b0;
      tick();
      tick();
      tick();
      check("pre_abort_busy", 32'(Busy), 32'd1);
      #1 Reset_n = 1'b0;
      #1;
      check("abort_aval", 32'(Aval), 32'd0);
      check("abort_bval", 32'(Bval), 32'd0);
      check("abort_x", 32'(X), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      Reset_n = 1'b1;
      tick();
      check("abort_idle", 32'(Busy), 32'd0);
      do_load(8'h07);
      do_mult("post_abort", 8'hC5, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h63, 1'b1);

`ifdef SEQ_MULT_ACCUM_EN
      // -2 + 0x63 * 2 = 196
      do_mult("accum", 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC4, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
